clock_core: RTL and testbench
=============================

# clock_core

Timekeeping and display-sequencing controller for the electronic clock. It divides the board clock into a 1 Hz tick and keeps BCD seconds/minutes plus binary hour, date, month and year with a leap-year calendar. It also runs the display-mode state machine and the 12/24-hour flag from debounced button pulses, and generates the 2-bit digit-scan select. All of its outputs feed the seven-segment scan/decode stage directly.

## Interface

**Parameters**
- `SEC_DIV`, default 100_000_000: clk cycles per second tick. Must be ≥ 2.
- `SCAN_DIV`, default 100_000: clk cycles per digit-scan step. Must be ≥ 2.

**Ports**
- `clk` in 1: system clock; single clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `mode_btn` in 1: debounced one-cycle pulse; advances the display mode.
- `apm_btn` in 1: debounced one-cycle pulse; toggles `APM`.
- `sec1`, `sec2` out 4: seconds units and tens, BCD.
- `min1`, `min2` out 4: minutes units and tens, BCD.
- `hour` out 5: binary, 0–23.
- `date` out 5: binary, 1–31.
- `month` out 4: binary, 1–12.
- `year` out 8: binary, 0–99, meaning 2000–2099.
- `mode` out 2: display mode. 00 = year, 01 = month/date, 10 = hour/min, 11 = sec.
- `APM` out 1: 1 selects 12-hour display.
- `control` out 2: digit-scan select. 00 is the leftmost digit.
- `sec_tick` out 1: one-cycle pulse, high on the cycle the time advances.

## Operation

**Reset** (`rst_n` low, asynchronous): all outputs and internal counters take these values.
- `sec1`, `sec2`, `min1`, `min2`, `hour` = 0.
- `date` = 1, `month` = 1, `year` = 0.
- `mode` = 00, `APM` = 0, `control` = 00, `sec_tick` = 0.
- Both divider counters = 0.

**Second divider**
- Counts 0..`SEC_DIV`-1 and wraps to 0.
- Tick condition: the counter equals `SEC_DIV`-1. On that cycle `sec_tick` = 1 and the time update is applied at the clock edge.

**Time carry chain** (resolved entirely within one tick)
- Seconds: `sec1` 9→0 carries into `sec2`; `sec2`=5 with `sec1`=9 → both 0 and carries to minutes.
- Minutes: same BCD rule as seconds; 59 → 00 carries to hour.
- Hour: 23 → 0 carries to date.
- Date: last day of month → 1 and carries to month.
  - Days per month: 31 for months 1, 3, 5, 7, 8, 10, 12; 30 for months 4, 6, 9, 11.
  - February: 29 when `year[1:0]`==0 (year 0 = 2000 is a leap year), otherwise 28.
- Month: 12 → 1 and carries to year.
- Year: 99 → 0.

**Mode FSM**
- States: YEAR(00) → MD(01) → HM(10) → SEC(11) → YEAR.
- Advances one state per `mode_btn` pulse; holds otherwise.

**APM**
- Toggles on each `apm_btn` pulse.
- It is a display flag only; timekeeping always runs in 24-hour form.

**Scan**
- A separate divider counts 0..`SCAN_DIV`-1.
- At `SCAN_DIV`-1, `control` increments modulo 4 (00→01→10→11→00).

**Simultaneous events**
- `mode_btn`, `apm_btn`, the second tick and the scan step are independent; all apply in the same cycle.
- A button pulse never stalls or delays the timekeeping.

## Timing

- All outputs are registered; no combinational path from input to output.
- Time outputs change on the clock edge that ends the tick cycle. The first tick after reset is at cycle `SEC_DIV`-1, so `sec1` = 1 from cycle `SEC_DIV` onward.
- Button latency: `mode`/`APM` change one edge after the pulse cycle.
- A pulse held high for N cycles acts N times. Single-cycle pulses are the caller's responsibility.
- `control` period is 4×`SCAN_DIV` cycles.
- Reset mid-count discards partial divider state. The count restarts from 0 when `rst_n` rises.

## Test plan

Run with `SEC_DIV`=4 and `SCAN_DIV`=2.

1. **Reset:** assert `rst_n`=0 mid-run → all outputs hold the reset values immediately (asynchronously). After release, the first `sec_tick` comes 4 cycles later and `sec1` becomes 1.
2. **Full rollover:** preload 23:59:59 on 2099-12-31 via force, then one tick → time 00:00:00, `date`=1, `month`=1, `year`=0, all on the same edge.
3. **February:**
   - `year`=24, Feb 28 23:59:59 + 1 tick → date 29.
   - `year`=23, same start → Mar 1.
   - Apr 30 rollover → May 1.
4. **Mode FSM:** 5 `mode_btn` pulses → `mode` sequence 01, 10, 11, 00, 01. A pulse landing on a tick cycle still advances `mode` and the seconds both increment.
5. **APM:** `apm_btn` pulse → `APM`=1; second pulse → 0. `hour` counting stays 24-hour across 12→13.
6. **Scan:** observe 16 cycles → `control` steps 00, 01, 10, 11, 00 every 2 cycles and is unaffected by button pulses.

Source files
------------

// File: rtl/clock_core_if.sv
// rtl/clock_core_if.sv - button inputs and display outputs of the clock core
interface clock_core_if;
  logic       mode_btn;
  logic       apm_btn;
  logic [3:0] sec1;
  logic [3:0] sec2;
  logic [3:0] min1;
  logic [3:0] min2;
  logic [4:0] hour;
  logic [4:0] date;
  logic [3:0] month;
  logic [7:0] year;
  logic [1:0] mode;
  logic       APM;
  logic [1:0] control;
  logic       sec_tick;

  // Board / bench side: supplies button pulses, consumes the display fields.
  modport master (
    output mode_btn, apm_btn,
    input  sec1, sec2, min1, min2, hour, date, month, year,
    input  mode, APM, control, sec_tick
  );

  // Clock core side.
  modport slave (
    input  mode_btn, apm_btn,
    output sec1, sec2, min1, min2, hour, date, month, year,
    output mode, APM, control, sec_tick
  );
endinterface

// File: rtl/clock_core.sv
// rtl/clock_core.sv - 1 Hz timekeeping, leap-year calendar, display mode and digit scan
module clock_core #(
  parameter int SEC_DIV  = 100_000_000,
  parameter int SCAN_DIV = 100_000
) (
  input  logic         clk,
  input  logic         rst_n,
  clock_core_if.slave  bus
);

  localparam int SEC_W  = $clog2(SEC_DIV);
  localparam int SCAN_W = $clog2(SCAN_DIV);

  localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(SEC_DIV - 1);
  localparam logic [SEC_W-1:0]  SEC_PRE   = SEC_W'(SEC_DIV - 2);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  localparam logic [1:0] MODE_YEAR = 2'b00;
  localparam logic [1:0] MODE_MD   = 2'b01;
  localparam logic [1:0] MODE_HM   = 2'b10;
  localparam logic [1:0] MODE_SEC  = 2'b11;

  logic [SEC_W-1:0]  sec_cnt;
  logic [SCAN_W-1:0] scan_cnt;

  logic [3:0] sec1_q, sec2_q, min1_q, min2_q;
  logic [4:0] hour_q, date_q;
  logic [3:0] month_q;
  logic [7:0] year_q;
  logic [1:0] mode_q;
  logic       apm_q;
  logic [1:0] control_q;
  logic       sec_tick_q;

  logic [3:0] sec1_n, sec2_n, min1_n, min2_n;
  logic [4:0] hour_n, date_n;
  logic [3:0] month_n;
  logic [7:0] year_n;
  logic [1:0] mode_n;

  logic       tick;
  logic       scan_step;
  logic [4:0] days_in_month;
  logic       c_min, c_hour, c_date, c_month, c_year;

  assign tick      = (sec_cnt == SEC_LAST);
  assign scan_step = (scan_cnt == SCAN_LAST);

  // Month length; year 0 (2000) is a leap year, and no century exception falls in range.
  always_comb begin
    days_in_month = 5'd31;
    case (month_q)
      4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
      4'd2:                    days_in_month = (year_q[1:0] == 2'b00) ? 5'd29 : 5'd28;
      default:                 days_in_month = 5'd31;
    endcase
  end

  // Carry chain resolved in one cycle: every field holds unless its lower neighbour wraps.
  always_comb begin
    sec1_n  = sec1_q;
    sec2_n  = sec2_q;
    min1_n  = min1_q;
    min2_n  = min2_q;
    hour_n  = hour_q;
    date_n  = date_q;
    month_n = month_q;
    year_n  = year_q;

    c_min   = tick && (sec1_q == 4'd9) && (sec2_q == 4'd5);
    c_hour  = c_min && (min1_q == 4'd9) && (min2_q == 4'd5);
    c_date  = c_hour && (hour_q >= 5'd23);
    c_month = c_date && (date_q >= days_in_month);
    c_year  = c_month && (month_q >= 4'd12);

    if (tick) begin
      sec1_n = (sec1_q == 4'd9) ? 4'd0 : sec1_q + 4'd1;
      if (sec1_q == 4'd9)
        sec2_n = (sec2_q == 4'd5) ? 4'd0 : sec2_q + 4'd1;
    end

    if (c_min) begin
      min1_n = (min1_q == 4'd9) ? 4'd0 : min1_q + 4'd1;
      if (min1_q == 4'd9)
        min2_n = (min2_q == 4'd5) ? 4'd0 : min2_q + 4'd1;
    end

    if (c_hour)
      hour_n = (hour_q >= 5'd23) ? 5'd0 : hour_q + 5'd1;

    if (c_date)
      date_n = (date_q >= days_in_month) ? 5'd1 : date_q + 5'd1;

    if (c_month)
      month_n = (month_q >= 4'd12) ? 4'd1 : month_q + 4'd1;

    if (c_year)
      year_n = (year_q >= 8'd99) ? 8'd0 : year_q + 8'd1;
  end

  // Display mode cycles YEAR -> MD -> HM -> SEC -> YEAR on each button pulse.
  always_comb begin
    mode_n = mode_q;
    if (bus.mode_btn) begin
      case (mode_q)
        MODE_YEAR: mode_n = MODE_MD;
        MODE_MD:   mode_n = MODE_HM;
        MODE_HM:   mode_n = MODE_SEC;
        MODE_SEC:  mode_n = MODE_YEAR;
        default:   mode_n = MODE_YEAR;
      endcase
    end
  end

  // Second divider; sec_tick is registered one cycle ahead so it is high during the tick cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt    <= '0;
      sec_tick_q <= 1'b0;
    end else begin
      sec_cnt    <= tick ? '0 : sec_cnt + 1'b1;
      sec_tick_q <= (sec_cnt == SEC_PRE);
    end
  end

  // Time and calendar registers load their next value every cycle (hold when no carry).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec1_q  <= 4'd0;
      sec2_q  <= 4'd0;
      min1_q  <= 4'd0;
      min2_q  <= 4'd0;
      hour_q  <= 5'd0;
      date_q  <= 5'd1;
      month_q <= 4'd1;
      year_q  <= 8'd0;
    end else begin
      sec1_q  <= sec1_n;
      sec2_q  <= sec2_n;
      min1_q  <= min1_n;
      min2_q  <= min2_n;
      hour_q  <= hour_n;
      date_q  <= date_n;
      month_q <= month_n;
      year_q  <= year_n;
    end
  end

  // Button-driven display state; independent of timekeeping so a press never delays a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_YEAR;
      apm_q  <= 1'b0;
    end else begin
      mode_q <= mode_n;
      apm_q  <= apm_q ^ bus.apm_btn;
    end
  end

  // Digit-scan divider and 2-bit select, wrapping naturally modulo 4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      control_q <= 2'b00;
    end else begin
      scan_cnt  <= scan_step ? '0 : scan_cnt + 1'b1;
      control_q <= scan_step ? control_q + 2'd1 : control_q;
    end
  end

  assign bus.sec1     = sec1_q;
  assign bus.sec2     = sec2_q;
  assign bus.min1     = min1_q;
  assign bus.min2     = min2_q;
  assign bus.hour     = hour_q;
  assign bus.date     = date_q;
  assign bus.month    = month_q;
  assign bus.year     = year_q;
  assign bus.mode     = mode_q;
  assign bus.APM      = apm_q;
  assign bus.control  = control_q;
  assign bus.sec_tick = sec_tick_q;

endmodule

// File: tb/tb_clock_core.sv
// tb/tb_clock_core.sv - directed self-checking bench for clock_core
module tb_clock_core;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  clock_core_if bus ();

  clock_core #(
    .SEC_DIV  (4),
    .SCAN_DIV (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sec1"},    32'(bus.sec1), 0);
    check({tag, "_sec2"},    32'(bus.sec2), 0);
    check({tag, "_min1"},    32'(bus.min1), 0);
    check({tag, "_min2"},    32'(bus.min2), 0);
    check({tag, "_hour"},    32'(bus.hour), 0);
    check({tag, "_date"},    32'(bus.date), 1);
    check({tag, "_month"},   32'(bus.month), 1);
    check({tag, "_year"},    32'(bus.year), 0);
    check({tag, "_mode"},    32'(bus.mode), 0);
    check({tag, "_apm"},     32'(bus.APM), 0);
    check({tag, "_control"}, 32'(bus.control), 0);
    check({tag, "_tick"},    32'(bus.sec_tick), 0);
  endtask

  // Load a time/date while the divider is away from its tick; storage captures the forced values.
  task preload(input logic [3:0] s2, input logic [3:0] s1, input logic [3:0] m2,
               input logic [3:0] m1, input logic [4:0] h, input logic [4:0] d,
               input logic [3:0] mo, input logic [7:0] y);
    force dut.sec1_q  = s1;
    force dut.sec2_q  = s2;
    force dut.min1_q  = m1;
    force dut.min2_q  = m2;
    force dut.hour_q  = h;
    force dut.date_q  = d;
    force dut.month_q = mo;
    force dut.year_q  = y;
    step();
    release dut.sec1_q;
    release dut.sec2_q;
    release dut.min1_q;
    release dut.min2_q;
    release dut.hour_q;
    release dut.date_q;
    release dut.month_q;
    release dut.year_q;
  endtask

  // Run until the tick cycle, then across its edge; divider is back at 0 afterwards.
  task automatic advance_tick(input string tag);
    int n;
    n = 0;
    while (!bus.sec_tick && n < 10) begin
      step();
      n++;
    end
    check({tag, "_tick_seen"}, 32'(bus.sec_tick), 1);
    step();
  endtask

  int exp_mode [5] = '{1, 2, 3, 0, 1};

  initial begin
    errors       = 0;
    checks       = 0;
    rst_n        = 1'b0;
    bus.mode_btn = 1'b0;
    bus.apm_btn  = 1'b0;

    // Power-on reset state.
    #12;
    check_reset_values("por");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) step();
    check("run_sec1", 32'(bus.sec1), 1);

    // Asynchronous reset mid-cycle, away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    check("first_tick", 32'(bus.sec_tick), 1);
    check("first_tick_sec1", 32'(bus.sec1), 0);
    step();
    check("after_tick_sec1", 32'(bus.sec1), 1);
    check("after_tick_flag", 32'(bus.sec_tick), 0);

    // Full rollover 2099-12-31 23:59:59.
    preload(4'd5, 4'd9, 4'd5, 4'd9, 5'd23, 5'd31, 4'd12, 8'd99);
    advance_tick("roll");
    check("roll_sec1",  32'(bus.sec1), 0);
    check("roll_sec2",  32'(bus.sec2), 0);
    check("roll_min1",  32'(bus.min1), 0);
    check("roll_min2",  32'(bus.min2), 0);
    check("roll_hour",  32'(bus.hour), 0);
    check("roll_date",  32'(bus.date), 1);
    check("roll_month", 32'(bus.month), 1);
    check("roll_year",  32'(bus.year), 0);

    // Leap February 2024: 28th rolls to 29th.
    preload(4'd5, 4'd9, 4'd5, 4'd9, 5'd23, 5'd28, 4'd2, 8'd24);
    advance_tick("leap28");
    check("leap28_date",  32'(bus.date), 29);
    check("leap28_month", 32'(bus.month), 2);
    check("leap28_hour",  32'(bus.hour), 0);

    // Leap February 2024: 29th rolls to March 1.
    preload(4'd5, 4'd9, 4'd5, 4'd9, 5'd23, 5'd29, 4'd2, 8'd24);
    advance_tick("leap29");
    check("leap29_date",  32'(bus.date), 1);
    check("leap29_month", 32'(bus.month), 3);

    // Common February 2023: 28th rolls to March 1.
    preload(4'd5, 4'd9, 4'd5, 4'd9, 5'd23, 5'd28, 4'd2, 8'd23);
    advance_tick("feb23");
    check("feb23_date",  32'(bus.date), 1);
    check("feb23_month", 32'(bus.month), 3);
    check("feb23_year",  32'(bus.year), 23);

    // 30-day month: April 30 rolls to May 1.
    preload(4'd5, 4'd9, 4'd5, 4'd9, 5'd23, 5'd30, 4'd4, 8'd23);
    advance_tick("apr");
    check("apr_date",  32'(bus.date), 1);
    check("apr_month", 32'(bus.month), 5);

    // Mode sequence over five separate pulses.
    for (int i = 0; i < 5; i++) begin
      bus.mode_btn = 1'b1;
      step();
      bus.mode_btn = 1'b0;
      check($sformatf("mode_%0d", i), 32'(bus.mode), 32'(exp_mode[i]));
      step();
    end

    // Mode pulse on a tick cycle: both mode and seconds advance.
    advance_tick("align");
    preload(4'd1, 4'd7, 4'd3, 4'd0, 5'd8, 5'd10, 4'd6, 8'd23);
    step();
    step();
    check("coll_tick", 32'(bus.sec_tick), 1);
    bus.mode_btn = 1'b1;
    step();
    bus.mode_btn = 1'b0;
    check("coll_mode", 32'(bus.mode), 2);
    check("coll_sec1", 32'(bus.sec1), 8);
    check("coll_sec2", 32'(bus.sec2), 1);

    // APM toggles, and hours stay 24-hour across 12 -> 13.
    bus.apm_btn = 1'b1;
    step();
    bus.apm_btn = 1'b0;
    check("apm_on", 32'(bus.APM), 1);
    advance_tick("align2");
    preload(4'd5, 4'd9, 4'd5, 4'd9, 5'd12, 5'd10, 4'd6, 8'd23);
    advance_tick("h13");
    check("h13_hour", 32'(bus.hour), 13);
    check("h13_date", 32'(bus.date), 10);
    check("h13_apm",  32'(bus.APM), 1);
    bus.apm_btn = 1'b1;
    step();
    bus.apm_btn = 1'b0;
    check("apm_off", 32'(bus.APM), 0);

    // Scan select from a fresh reset, with button pulses mixed in.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("scan_rst", 32'(bus.control), 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      bus.mode_btn = (k == 3);
      bus.apm_btn  = (k == 5);
      step();
      bus.mode_btn = 1'b0;
      bus.apm_btn  = 1'b0;
      check($sformatf("scan_%0d", k), 32'(bus.control), 32'((k / 2) % 4));
    end
    check("scan_mode", 32'(bus.mode), 1);
    check("scan_apm",  32'(bus.APM), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
